hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding control for the five-stage pipeline.
// A three-deep scoreboard (EX, MEM, WB) records the writes in flight. It is
// compared against the ID sources to produce stall/bubble, branch flush and
// operand forward selects. A down-counter tracks HI/LO unit occupancy.
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_addra,
    input  logic [4:0] id_addrb,
    input  logic       id_usea,
    input  logic       id_useb,
    input  logic       id_isbranch,
    input  logic       id_brtaken,
    input  logic       id_writereg,
    input  logic [4:0] id_regdest,
    input  logic       id_readmem,
    input  logic       id_mdstart,
    input  logic       id_mdread,
    output logic       hz_stall_pc,
    output logic       hz_stall_ifid,
    output logic       hz_bubble_ex,
    output logic       hz_flush_ifid,
    output logic [1:0] hz_fwda,
    output logic [1:0] hz_fwdb,
    output logic       hz_mdbusy
);

    localparam int unsigned CntW = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CntW-1:0] MdLoad = CntW'(MULDIV_CYCLES);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       isload;
    } sb_entry_t;

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t new_entry;
    logic [CntW-1:0] mdcnt_q;

    logic a_ex, b_ex, a_mem, b_mem, a_wb, b_wb;
    logic load_use, br_haz, md_haz, stall;

    // $0 is hardwired, so it never takes part in a dependency.
    function automatic logic src_match(logic use_src, logic [4:0] src, sb_entry_t e);
        return use_src && (src != 5'd0) && e.valid && (e.dest == src);
    endfunction

    // MEM beats WB; a load sitting in MEM has no result to forward yet.
    function automatic logic [1:0] fwd_sel(logic m_mem, logic m_wb, logic mem_isload);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_mem && !mem_isload) begin
            sel = 2'b01;
        end else if (m_wb) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign hz_mdbusy = (mdcnt_q != '0);

    // Source/scoreboard matches and the combined stall decision.
    always_comb begin
        a_ex     = src_match(id_usea, id_addra, ex_q);
        b_ex     = src_match(id_useb, id_addrb, ex_q);
        a_mem    = src_match(id_usea, id_addra, mem_q);
        b_mem    = src_match(id_useb, id_addrb, mem_q);
        a_wb     = src_match(id_usea, id_addra, wb_q);
        b_wb     = src_match(id_useb, id_addrb, wb_q);
        load_use = (a_ex | b_ex) & ex_q.isload;
        // Branches compare in ID, so they also wait for ALU results still in EX.
        br_haz   = id_isbranch & ((a_ex | b_ex) | ((a_mem | b_mem) & mem_q.isload));
        md_haz   = (id_mdread | id_mdstart) & hz_mdbusy;
        stall    = id_valid & (load_use | br_haz | md_haz);
    end

    // Stall, flush and forward outputs.
    always_comb begin
        hz_stall_pc   = stall;
        hz_stall_ifid = stall;
        hz_bubble_ex  = stall;
        hz_flush_ifid = id_valid & id_isbranch & id_brtaken & ~stall;
        hz_fwda       = fwd_sel(a_mem, a_wb, mem_q.isload);
        hz_fwdb       = fwd_sel(b_mem, b_wb, mem_q.isload);
    end

    // Entry for the instruction leaving ID; a stall inserts a bubble.
    always_comb begin
        new_entry.valid  = id_valid & id_writereg & (id_regdest != 5'd0) & ~stall;
        new_entry.dest   = id_regdest;
        new_entry.isload = id_readmem;
    end

    // Scoreboard shifts every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= new_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // HI/LO occupancy counter: load on an accepted start, else count down to 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdcnt_q <= '0;
        end else if (id_valid && id_mdstart && !stall) begin
            mdcnt_q <= MdLoad;
        end else if (mdcnt_q != '0) begin
            mdcnt_q <= mdcnt_q - CntW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams checked against a queue/timestamp reference model.
module tb_hazard_ctrl;

    localparam int unsigned MD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_usea, id_useb, id_isbranch, id_brtaken, id_writereg;
    logic       id_readmem, id_mdstart, id_mdread;
    logic [4:0] id_addra, id_addrb, id_regdest;
    logic       hz_stall_pc, hz_stall_ifid, hz_bubble_ex, hz_flush_ifid, hz_mdbusy;
    logic [1:0] hz_fwda, hz_fwdb;

    always #5 clock = ~clock;

    hazard_ctrl #(.MULDIV_CYCLES(MD)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_addra     (id_addra),
        .id_addrb     (id_addrb),
        .id_usea      (id_usea),
        .id_useb      (id_useb),
        .id_isbranch  (id_isbranch),
        .id_brtaken   (id_brtaken),
        .id_writereg  (id_writereg),
        .id_regdest   (id_regdest),
        .id_readmem   (id_readmem),
        .id_mdstart   (id_mdstart),
        .id_mdread    (id_mdread),
        .hz_stall_pc  (hz_stall_pc),
        .hz_stall_ifid(hz_stall_ifid),
        .hz_bubble_ex (hz_bubble_ex),
        .hz_flush_ifid(hz_flush_ifid),
        .hz_fwda      (hz_fwda),
        .hz_fwdb      (hz_fwdb),
        .hz_mdbusy    (hz_mdbusy)
    );

    // Reference model: writes in flight, youngest first; HI/LO free time.
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       ld;
    } ent_t;

    ent_t       pipe[$];
    int         cyc = 0;
    int         md_free = 0;
    int         checks = 0;
    int         errors = 0;
    logic       e_stall, e_flush, e_busy;
    logic [1:0] e_fwda, e_fwdb;

    task automatic clear_model();
        ent_t z;
        z = '{v: 1'b0, d: 5'd0, ld: 1'b0};
        pipe.delete();
        repeat (3) pipe.push_back(z);
        md_free = 0;
    endtask

    // k: 0 = one instruction ahead, 1 = two ahead, 2 = three ahead.
    function automatic bit hit(int k, bit use_src, logic [4:0] src);
        return use_src && (src != 5'd0) && pipe[k].v && (pipe[k].d == src);
    endfunction

    function automatic logic [1:0] fsel(bit m1, bit m2, bit ld1);
        if (m1 && !ld1) return 2'b01;
        if (m2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model();
        bit a0, b0, a1, b1, a2, b2, haz;
        a0 = hit(0, id_usea, id_addra);
        b0 = hit(0, id_useb, id_addrb);
        a1 = hit(1, id_usea, id_addra);
        b1 = hit(1, id_useb, id_addrb);
        a2 = hit(2, id_usea, id_addra);
        b2 = hit(2, id_useb, id_addrb);
        e_busy = (cyc < md_free);
        haz = ((a0 || b0) && pipe[0].ld)
            || (id_isbranch && (a0 || b0 || ((a1 || b1) && pipe[1].ld)))
            || ((id_mdread || id_mdstart) && e_busy);
        e_stall = id_valid && haz;
        e_flush = id_valid && id_isbranch && id_brtaken && !e_stall;
        e_fwda  = fsel(a1, a2, pipe[1].ld);
        e_fwdb  = fsel(b1, b2, pipe[1].ld);
    endtask

    task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic mid(string tag);
        bit empty;
        #3;
        model();
        empty = !(pipe[0].v || pipe[1].v || pipe[2].v);
        chk({tag, ".stall_pc"}, {1'b0, hz_stall_pc}, {1'b0, e_stall});
        chk({tag, ".stall_ifid"}, {1'b0, hz_stall_ifid}, {1'b0, e_stall});
        chk({tag, ".bubble"}, {1'b0, hz_bubble_ex}, {1'b0, e_stall});
        chk({tag, ".flush"}, {1'b0, hz_flush_ifid}, {1'b0, e_flush});
        chk({tag, ".mdbusy"}, {1'b0, hz_mdbusy}, {1'b0, e_busy});
        if (id_valid || empty) begin
            chk({tag, ".fwda"}, hz_fwda, e_fwda);
            chk({tag, ".fwdb"}, hz_fwdb, e_fwdb);
        end
    endtask

    // Clock edge: retire the oldest write, admit the ID instruction.
    task automatic adv();
        ent_t n;
        model();
        @(posedge clock);
        if (reset) begin
            clear_model();
        end else begin
            n.v  = id_valid && id_writereg && (id_regdest != 5'd0) && !e_stall;
            n.d  = id_regdest;
            n.ld = id_readmem;
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (id_valid && id_mdstart && !e_stall) md_free = cyc + 1 + MD;
        end
        cyc++;
        #1;
    endtask

    task automatic step(string tag);
        mid(tag);
        adv();
    endtask

    task automatic put(bit v, logic [4:0] a, logic [4:0] b, bit ua, bit ub, bit br, bit bt,
                       bit wr, logic [4:0] d, bit ld, bit ms, bit mr);
        id_valid    = v;
        id_addra    = a;
        id_addrb    = b;
        id_usea     = ua;
        id_useb     = ub;
        id_isbranch = br;
        id_brtaken  = bt;
        id_writereg = wr;
        id_regdest  = d;
        id_readmem  = ld;
        id_mdstart  = ms;
        id_mdread   = mr;
    endtask

    task automatic idle();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic alu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        put(1, rs, rt, 1, 1, 0, 0, 1, rd, 0, 0, 0);
    endtask
    task automatic lw(logic [4:0] rt, logic [4:0] rs);
        put(1, rs, 0, 1, 0, 0, 0, 1, rt, 1, 0, 0);
    endtask
    task automatic beq(logic [4:0] rs, logic [4:0] rt, bit taken);
        put(1, rs, rt, 1, 1, 1, taken, 0, 0, 0, 0, 0);
    endtask
    task automatic mult(logic [4:0] rs, logic [4:0] rt);
        put(1, rs, rt, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    endtask
    task automatic mfhi(logic [4:0] rd);
        put(1, 0, 0, 0, 0, 0, 0, 1, rd, 0, 0, 1);
    endtask

    task automatic drain();
        idle();
        repeat (3) step("drain");
    endtask

    task automatic all_zero(string tag);
        chk({tag, ".stall"}, {1'b0, hz_stall_pc}, 2'd0);
        chk({tag, ".bubble"}, {1'b0, hz_bubble_ex}, 2'd0);
        chk({tag, ".flush"}, {1'b0, hz_flush_ifid}, 2'd0);
        chk({tag, ".mdbusy"}, {1'b0, hz_mdbusy}, 2'd0);
        chk({tag, ".fwda"}, hz_fwda, 2'd0);
        chk({tag, ".fwdb"}, hz_fwdb, 2'd0);
    endtask

    initial begin
        clear_model();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        #1;
        all_zero("in_reset");
        reset = 1'b0;
        step("post_reset");

        // Load-use: one stall, then the add proceeds.
        lw(5, 1);
        step("lu_lw");
        alu(6, 5, 1);
        mid("lu_add1");
        chk("lu_stall1", {1'b0, hz_bubble_ex}, 2'd1);
        adv();
        mid("lu_add2");
        chk("lu_stall2", {1'b0, hz_stall_pc}, 2'd0);
        adv();
        drain();

        // ALU result one ahead: no stall; two ahead: MEM forward; three ahead: WB.
        alu(3, 1, 2);
        step("fw_add");
        alu(4, 3, 3);
        mid("fw_sub0");
        chk("fw_nostall", {1'b0, hz_stall_pc}, 2'd0);
        adv();
        alu(3, 1, 2);
        step("fw_add_b");
        alu(9, 1, 2);
        step("fw_indep");
        alu(4, 3, 3);
        mid("fw_sub1");
        chk("fw_mem_a", hz_fwda, 2'b01);
        chk("fw_mem_b", hz_fwdb, 2'b01);
        adv();
        alu(3, 1, 2);
        step("fw_add_c");
        alu(9, 1, 2);
        step("fw_indep2");
        alu(10, 1, 2);
        step("fw_indep3");
        alu(4, 3, 1);
        mid("fw_sub2");
        chk("fw_wb_a", hz_fwda, 2'b10);
        chk("fw_wb_b", hz_fwdb, 2'b00);
        adv();
        // Both MEM and WB hold $3: MEM wins.
        alu(3, 1, 2);
        step("pr_add1");
        alu(3, 1, 2);
        step("pr_add2");
        alu(9, 1, 2);
        step("pr_indep");
        alu(4, 3, 3);
        mid("pr_sub");
        chk("pr_mem_wins", hz_fwda, 2'b01);
        adv();
        drain();

        // Branch after ALU: one stall then flush; after load: two stalls then flush.
        alu(2, 1, 1);
        step("br_add");
        beq(2, 7, 1);
        mid("br_beq1");
        chk("br_stall1", {1'b0, hz_stall_ifid}, 2'd1);
        chk("br_noflush1", {1'b0, hz_flush_ifid}, 2'd0);
        adv();
        mid("br_beq2");
        chk("br_flush", {1'b0, hz_flush_ifid}, 2'd1);
        adv();
        drain();
        lw(2, 1);
        step("brl_lw");
        beq(2, 7, 1);
        mid("brl_beq1");
        chk("brl_stall1", {1'b0, hz_stall_pc}, 2'd1);
        adv();
        mid("brl_beq2");
        chk("brl_stall2", {1'b0, hz_stall_pc}, 2'd1);
        adv();
        mid("brl_beq3");
        chk("brl_stall3", {1'b0, hz_stall_pc}, 2'd0);
        chk("brl_flush", {1'b0, hz_flush_ifid}, 2'd1);
        adv();
        drain();

        // mult then mfhi: busy and stalled for MD cycles.
        mult(1, 2);
        step("md_mult");
        mfhi(8);
        for (int k = 0; k < int'(MD); k++) begin
            mid("md_wait");
            chk("md_busy", {1'b0, hz_mdbusy}, 2'd1);
            chk("md_stall", {1'b0, hz_stall_pc}, 2'd1);
            adv();
        end
        mid("md_go");
        chk("md_idle", {1'b0, hz_mdbusy}, 2'd0);
        chk("md_accept", {1'b0, hz_stall_pc}, 2'd0);
        adv();
        drain();

        // $0 destination never creates a dependency.
        lw(0, 1);
        step("z_lw");
        alu(6, 0, 0);
        mid("z_add");
        chk("z_nostall", {1'b0, hz_stall_pc}, 2'd0);
        chk("z_fwda", hz_fwda, 2'd0);
        chk("z_fwdb", hz_fwdb, 2'd0);
        adv();
        drain();

        // Asynchronous reset with mdcnt=3 clears everything without a clock edge.
        mult(1, 2);
        step("ar_mult");
        idle();
        step("ar_cnt4");
        #1;
        chk("ar_busy_before", {1'b0, hz_mdbusy}, 2'd1);
        reset = 1'b1;
        #1;
        all_zero("ar_md");
        clear_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("ar_after");

        // Asynchronous reset during a load-use stall clears the stall.
        lw(5, 1);
        step("as_lw");
        alu(6, 5, 1);
        #2;
        chk("as_stall_before", {1'b0, hz_stall_pc}, 2'd1);
        reset = 1'b1;
        #1;
        all_zero("as_rst");
        clear_model();
        @(posedge clock);
        #1;
        idle();
        reset = 1'b0;
        step("as_after");

        // Random streams; a stalled instruction is held, a flushed slot is empty.
        for (int i = 0; i < 3000; i++) begin
            if (!e_stall) begin
                put($urandom_range(0, 9) != 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
                if (e_flush) id_valid = 1'b0;
            end
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
